// File: rtl/alu_b_mux_pkg.sv
// Shared select encodings and defaults for the ALU operand-B source mux.
package alu_b_mux_pkg;

    typedef logic [2:0] alu_b_sel_t;

    localparam alu_b_sel_t SEL_B    = 3'd0;
    localparam alu_b_sel_t SEL_FOUR = 3'd1;
    localparam alu_b_sel_t SEL_SHL2 = 3'd2;
    localparam alu_b_sel_t SEL_SEXT = 3'd3;
    localparam alu_b_sel_t SEL_MEM  = 3'd4;

    localparam int PC_INC_DEFAULT = 4;

    function automatic logic sel_is_legal(input alu_b_sel_t sel);
        return (sel <= SEL_MEM);
    endfunction

endpackage

// File: rtl/alu_b_mux_sel_check.sv
// Sticky illegal-select flag for the operand-B mux, plus a simulation check
// that the controller never drives an encoding above SEL_MEM.
module alu_b_mux_sel_check
    import alu_b_mux_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  alu_b_sel_t sel_i,
    output logic       sel_err_o
);

    logic sel_err_q;
    logic sel_err_d;

    always_comb begin
        sel_err_d = sel_err_q;
        if (!sel_is_legal(sel_i)) begin
            sel_err_d = 1'b1;
        end
    end

    // Reset wins over an illegal select on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err_o = sel_err_q;

    always @(posedge clk) begin
        if (!reset) begin
            assert (sel_is_legal(sel_i))
            else $error("alu_b_mux: illegal ALUSrcB %0d", sel_i);
        end
    end

endmodule

// File: rtl/alu_b_mux.sv
// ALU operand-B source mux for the multicycle datapath, with a registered copy.
// Optional: ALU_B_MUX_SEL_CHECK_EN enables the sticky Sel_err flag and select check.
module alu_b_mux
    import alu_b_mux_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_INC = PC_INC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        ALUSrcB,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] Shift_Left_2,
    input  logic [DATA_W-1:0] Sign_Extend,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic [DATA_W-1:0] Data_out,
    output logic [DATA_W-1:0] Data_out_q,
    output logic              Sel_err
);

    localparam logic [DATA_W-1:0] PC_INC_W = DATA_W'(PC_INC);

    logic [DATA_W-1:0] data_out_q;

    // Unused and unknown encodings fall to the default so X never reaches the ALU.
    always_comb begin
        Data_out = '0;
        case (ALUSrcB)
            SEL_B:    Data_out = B;
            SEL_FOUR: Data_out = PC_INC_W;
            SEL_SHL2: Data_out = Shift_Left_2;
            SEL_SEXT: Data_out = Sign_Extend;
            SEL_MEM:  Data_out = Mem_Data;
            default:  Data_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= Data_out;
        end
    end

    assign Data_out_q = data_out_q;

`ifdef ALU_B_MUX_SEL_CHECK_EN
    alu_b_mux_sel_check u_sel_check (
        .clk       (clk),
        .reset     (reset),
        .sel_i     (ALUSrcB),
        .sel_err_o (Sel_err)
    );
`else
    assign Sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_b_mux.sv
// Scoreboard bench for alu_b_mux: stimulus pushes expected values, a monitor pops and compares.
module tb_alu_b_mux;

    localparam int DATA_W = 32;
`ifdef ALU_B_MUX_SEL_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        ALUSrcB;
    logic [DATA_W-1:0] B, Shift_Left_2, Sign_Extend, Mem_Data;
    logic [DATA_W-1:0] Data_out, Data_out_q;
    logic              Sel_err;

    alu_b_mux #(.DATA_W(DATA_W), .PC_INC(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .ALUSrcB      (ALUSrcB),
        .B            (B),
        .Shift_Left_2 (Shift_Left_2),
        .Sign_Extend  (Sign_Extend),
        .Mem_Data     (Mem_Data),
        .Data_out     (Data_out),
        .Data_out_q   (Data_out_q),
        .Sel_err      (Sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] dout;
        logic [DATA_W-1:0] dout_q;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    logic [DATA_W-1:0] m_q   = '0;
    logic              m_err = 1'b0;

    // Reference: the five sources as a table indexed by select; anything else reads 0.
    function automatic logic [DATA_W-1:0] ref_dout(input int sel,
            input logic [DATA_W-1:0] b, sl2, sx, mem);
        logic [DATA_W-1:0] src[5];
        src[0] = b; src[1] = 32'd4; src[2] = sl2; src[3] = sx; src[4] = mem;
        return (sel >= 0 && sel < 5) ? src[sel] : '0;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue what must appear after the next rise.
    task automatic apply(input logic rst, input int sel, input logic [DATA_W-1:0] b, sl2, sx, mem);
        exp_t e;
        @(negedge clk);
        reset = rst; ALUSrcB = 3'(sel);
        B = b; Shift_Left_2 = sl2; Sign_Extend = sx; Mem_Data = mem;
        e.dout = ref_dout(sel, b, sl2, sx, mem);
        if (rst) begin
            m_q = '0; m_err = 1'b0;
        end else begin
            m_q = e.dout;
            if (CHECK_EN && sel > 4) m_err = 1'b1;
        end
        e.dout_q = m_q;
        e.err    = m_err;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [DATA_W-1:0] act, exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs settle at negedge, so #1 after each rise samples a stable cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("Data_out",   Data_out,   e.dout);
                check("Data_out_q", Data_out_q, e.dout_q);
                check("Sel_err",    {31'b0, Sel_err}, {31'b0, e.err});
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1; ALUSrcB = '0;
        B = '0; Shift_Left_2 = '0; Sign_Extend = '0; Mem_Data = '0;

        apply(1, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0);
        apply(0, 2, 0, 3, 0, 0);
        apply(0, 3, 0, 0, 4, 0);
        apply(0, 4, 5, 0, 0, 5);
        apply(0, 4, 9, 0, 0, 5);
        apply(0, 6, '1, '1, '1, '1);
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 32'h1234_5678, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 5, 0, 0, 0, 0);
        apply(1, 7, '1, '1, '1, '1);
        apply(1, 0, 32'hA5A5_A5A5, 0, 0, 0);
        apply(0, 0, 32'hA5A5_A5A5, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            apply($urandom_range(0, 24) == 0, sel, $urandom, $urandom, $urandom, $urandom);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_b_mux.md
Name: alu_b_mux

Overview:
- Selects the ALU operand-B source in the multicycle MIPS datapath under the 3-bit control ALUSrcB.
- Sources: register B, constant 4 (PC increment), shifted immediate, sign-extended immediate and memory data.
- Data_out is combinational, so the ALU sees the selected operand in the same cycle.
- Also provides a registered copy of the operand and a sticky illegal-select flag for debug and verification.

Parameters:
- DATA_W, 32, width of every data input and output.
- PC_INC, 4, constant driven when ALUSrcB=1.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- ALUSrcB  in  3  source select.
- B  in  DATA_W  register-file B operand.
- Shift_Left_2  in  DATA_W  immediate shifted left by 2.
- Sign_Extend  in  DATA_W  sign-extended immediate.
- Mem_Data  in  DATA_W  memory data register value.
- Data_out  out  DATA_W  selected operand, combinational.
- Data_out_q  out  DATA_W  Data_out registered on clk.
- Sel_err  out  1  sticky flag: illegal ALUSrcB seen.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Select map for Data_out (zero latency, purely combinational, independent of clk and reset):
  - 0 -> B
  - 1 -> PC_INC (value 4)
  - 2 -> Shift_Left_2
  - 3 -> Sign_Extend
  - 4 -> Mem_Data
- ALUSrcB 5, 6 or 7 -> Data_out = 0.
- No arithmetic and no width conversion; inputs pass bit-exact.
- X/Z on ALUSrcB -> Data_out = 0. It must not propagate X (use a default branch).
- Data_out_q:
  - At each rising clk with reset=1, loads 0.
  - Otherwise loads the current Data_out. One-cycle latency.
- Sel_err:
  - Cleared to 0 on a reset edge.
  - With the feature enabled, set at a rising clk when ALUSrcB is in 5..7.
  - Once set, stays 1 until reset.
  - Reset takes priority when an illegal select and reset occur on the same edge.
- Reset mid-operation affects only the registered outputs; Data_out continues to track its inputs.
- Output values after reset: Data_out_q=0, Sel_err=0.

Optional Feature:
- Macro: ALU_B_MUX_SEL_CHECK_EN.
- Defined:
  - Sel_err latches illegal selects as described above.
  - Simulation-only assertion: at each rising clk with reset=0, ALUSrcB must be 0..4; otherwise an $error is reported.
- Undefined: Sel_err is tied to 0; no assertion logic. Data_out and Data_out_q are unaffected.

Decomposition:
- Shared package alu_b_mux_pkg holds:
  - select constants SEL_B=0, SEL_FOUR=1, SEL_SHL2=2, SEL_SEXT=3, SEL_MEM=4;
  - the alu_b_sel_t 3-bit typedef;
  - the default PC_INC value.
- Natural sub-module: alu_b_mux_sel_check, containing the Sel_err register and the assertion, instantiated only under the macro.
- Core mux and Data_out_q register stay in the top module.

Test Plan:
- Select B: ALUSrcB=0, B=1, others 0 -> Data_out=1; next edge Data_out_q=1.
- Constant source: ALUSrcB=1, B=0, others 0 -> Data_out=4.
- Shifted and sign-extended sources:
  - ALUSrcB=2, Shift_Left_2=3 -> Data_out=3.
  - ALUSrcB=3, Sign_Extend=4 -> Data_out=4.
- Memory source: ALUSrcB=4, B=5, Mem_Data=5 -> Data_out=5. Then B=9 with Mem_Data=5 -> Data_out stays 5, proving B is not selected.
- Illegal select (macro defined): ALUSrcB=6, all inputs 0xFFFFFFFF.
  - Data_out=0.
  - After the edge, Sel_err=1; it stays 1 after ALUSrcB returns to 0.
  - Assert reset for one edge -> Sel_err=0 and Data_out_q=0.
- Reset priority: reset=1 and ALUSrcB=7 on the same edge -> Sel_err=0, Data_out_q=0. Data_out meanwhile follows its inputs (B=0xA5A5A5A5 with ALUSrcB=0 -> 0xA5A5A5A5 during reset).
